// File: rtl/commit_unit.sv
// In-order commit stage: retires executed ROB head slots, queues their previous
// physical destinations in a small release FIFO toward the free list, and supports halting.
module commit_unit #(
    parameter int INSTR_COUNT  = 2,
    parameter int P_ADDR_WIDTH = 7,
    parameter int REL_DEPTH    = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [INSTR_COUNT-1:0]                   rob_valid,
    input  logic [INSTR_COUNT-1:0]                   rob_exec,
    input  logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0] rob_ppdst,
    output logic [INSTR_COUNT-1:0]                   rob_pop,
    input  logic                                     rec_en,
    input  logic                                     halt_req,
    output logic                                     halted,
    output logic                                     fl_valid,
    input  logic                                     fl_ready,
    output logic [INSTR_COUNT-1:0]                   fl_mask,
    output logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0] fl_data,
    output logic [31:0]                              retire_cnt
);

    localparam int PTR_W = $clog2(REL_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(REL_DEPTH);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic [INSTR_COUNT-1:0]                   mask_mem [REL_DEPTH];
    logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0] data_mem [REL_DEPTH];

    logic                   commit_ok;
    logic [INSTR_COUNT-1:0] slot_ready;
    logic                   push;
    logic                   pop;
    logic [31:0]            pop_num;

    // A full FIFO blocks commit outright; a same-cycle dequeue does not free a slot.
    assign commit_ok  = !rst && (state == RUN) && !rec_en && (count < FULL_COUNT);
    assign slot_ready = rob_valid & rob_exec;

    // Slot i retires only if every older slot retires too, so the pop mask is a thermometer.
    for (genvar i = 0; i < INSTR_COUNT; i++) begin : g_pop
        assign rob_pop[i] = commit_ok & (&slot_ready[i:0]);
    end

    assign push     = |rob_pop;
    assign fl_valid = (count != '0);
    assign pop      = fl_valid & fl_ready;
    assign fl_mask  = fl_valid ? mask_mem[rd_ptr] : '0;
    assign fl_data  = data_mem[rd_ptr];

    always_comb begin
        pop_num = '0;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            pop_num = pop_num + {31'd0, rob_pop[i]};
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (halt_req) next_state = DRAIN;
            DRAIN: begin
                if (!halt_req)         next_state = RUN;
                else if (count == '0)  next_state = HALTED;
            end
            HALTED:  if (!halt_req) next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            halted     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            retire_cnt <= '0;
        end else begin
            state      <= next_state;
            halted     <= (next_state == HALTED);
            retire_cnt <= retire_cnt + pop_num;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; stale entries are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr] <= rob_pop;
            data_mem[wr_ptr] <= rob_ppdst;
        end
    end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: vector table for single-cycle commit behaviour
// plus hand-written sequences for FIFO full, halt, recovery and mid-operation reset.
module tb_commit_unit;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       rob_valid = '0;
    logic [1:0]       rob_exec = '0;
    logic [1:0][6:0]  rob_ppdst = '0;
    logic [1:0]       rob_pop;
    logic             rec_en = 1'b0;
    logic             halt_req = 1'b0;
    logic             halted;
    logic             fl_valid;
    logic             fl_ready = 1'b0;
    logic [1:0]       fl_mask;
    logic [1:0][6:0]  fl_data;
    logic [31:0]      retire_cnt;

    int errors = 0;
    int checks = 0;

    commit_unit #(.INSTR_COUNT(2), .P_ADDR_WIDTH(7), .REL_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .rob_valid(rob_valid), .rob_exec(rob_exec), .rob_ppdst(rob_ppdst),
        .rob_pop(rob_pop), .rec_en(rec_en), .halt_req(halt_req), .halted(halted),
        .fl_valid(fl_valid), .fl_ready(fl_ready), .fl_mask(fl_mask),
        .fl_data(fl_data), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] valid;
        logic [1:0] exec;
        logic [6:0] pp1;
        logic [6:0] pp0;
        logic       rec;
        logic [1:0] exp_pop;
        logic       exp_flv;
        logic [1:0] exp_mask;
        logic [6:0] exp_d1;
        logic [6:0] exp_d0;
        int         exp_ret;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] exec,
                                 input logic [6:0] pp1, input logic [6:0] pp0,
                                 input logic rec, input logic halt, input logic ready);
        rob_valid    = valid;
        rob_exec     = exec;
        rob_ppdst[1] = pp1;
        rob_ppdst[0] = pp0;
        rec_en       = rec;
        halt_req     = halt;
        fl_ready     = ready;
    endtask

    // One cycle: drive after the falling edge, check the combinational pop, then let the edge happen.
    task automatic step(input logic [1:0] valid, input logic [1:0] exec,
                        input logic [6:0] pp1, input logic [6:0] pp0,
                        input logic rec, input logic halt, input logic ready,
                        input logic [1:0] exp_pop, input string name);
        @(negedge clk);
        applyStimulus(valid, exec, pp1, pp0, rec, halt, ready);
        #1;
        checkOutput(name, {30'd0, rob_pop}, {30'd0, exp_pop});
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        applyStimulus(2'b11, 2'b11, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rst_pop", {30'd0, rob_pop}, 32'd0);
        checkOutput("rst_flv", {31'd0, fl_valid}, 32'd0);
        checkOutput("rst_mask", {30'd0, fl_mask}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("rst_ret", retire_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(2'b00, 2'b00, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{2'b11, 2'b11, 7'd9,  7'd5,  1'b0, 2'b11, 1'b1, 2'b11, 7'd9,  7'd5,  2};
        vecs[1] = '{2'b11, 2'b10, 7'd3,  7'd4,  1'b0, 2'b00, 1'b0, 2'b00, 7'd0,  7'd0,  2};
        vecs[2] = '{2'b11, 2'b01, 7'd6,  7'd7,  1'b0, 2'b01, 1'b1, 2'b01, 7'd0,  7'd7,  3};
        vecs[3] = '{2'b01, 2'b11, 7'd1,  7'd2,  1'b0, 2'b01, 1'b1, 2'b01, 7'd0,  7'd2,  4};
        vecs[4] = '{2'b00, 2'b11, 7'd1,  7'd2,  1'b0, 2'b00, 1'b0, 2'b00, 7'd0,  7'd0,  4};
        vecs[5] = '{2'b11, 2'b11, 7'd8,  7'd10, 1'b1, 2'b00, 1'b0, 2'b00, 7'd0,  7'd0,  4};
        vecs[6] = '{2'b11, 2'b11, 7'd12, 7'd13, 1'b0, 2'b11, 1'b1, 2'b11, 7'd12, 7'd13, 6};

        // Table-driven single-cycle behaviour with the free list always ready
        doReset();
        for (int i = 0; i < 7; i++) begin
            step(vecs[i].valid, vecs[i].exec, vecs[i].pp1, vecs[i].pp0, vecs[i].rec, 1'b0, 1'b1,
                 vecs[i].exp_pop, "vec_pop");
            checkOutput("vec_flv", {31'd0, fl_valid}, {31'd0, vecs[i].exp_flv});
            checkOutput("vec_mask", {30'd0, fl_mask}, {30'd0, vecs[i].exp_mask});
            if (vecs[i].exp_mask[0]) checkOutput("vec_d0", {25'd0, fl_data[0]}, {25'd0, vecs[i].exp_d0});
            if (vecs[i].exp_mask[1]) checkOutput("vec_d1", {25'd0, fl_data[1]}, {25'd0, vecs[i].exp_d1});
            checkOutput("vec_ret", retire_cnt, vecs[i].exp_ret);
            checkOutput("vec_halted", {31'd0, halted}, 32'd0);
        end

        // FIFO fills to four entries, then drains in push order
        doReset();
        for (int k = 0; k < 6; k++) begin
            step(2'b11, 2'b11, 7'(2*k+1), 7'(2*k), 1'b0, 1'b0, 1'b0,
                 (k < 4) ? 2'b11 : 2'b00, "full_pop");
        end
        checkOutput("full_ret", retire_cnt, 32'd8);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            applyStimulus(2'b00, 2'b00, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
            #1;
            checkOutput("drain_flv", {31'd0, fl_valid}, 32'd1);
            checkOutput("drain_d0", {25'd0, fl_data[0]}, 32'(2*k));
            checkOutput("drain_d1", {25'd0, fl_data[1]}, 32'(2*k+1));
            @(posedge clk);
            #1;
        end
        checkOutput("drain_empty", {31'd0, fl_valid}, 32'd0);

        // Halt with three queued entries
        doReset();
        for (int k = 0; k < 3; k++) begin
            step(2'b11, 2'b11, 7'(20+k), 7'(10+k), 1'b0, 1'b0, 1'b0, 2'b11, "hq_pop");
        end
        step(2'b00, 2'b00, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0, 2'b00, "halt_idle");
        checkOutput("halt_h0", {31'd0, halted}, 32'd0);
        step(2'b11, 2'b11, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0, 2'b00, "halt_pop");
        for (int d = 1; d <= 4; d++) begin
            step(2'b11, 2'b11, 7'd0, 7'd0, 1'b0, 1'b1, 1'b1, 2'b00, "drainh_pop");
            checkOutput("drainh_halted", {31'd0, halted}, (d == 4) ? 32'd1 : 32'd0);
            checkOutput("drainh_flv", {31'd0, fl_valid}, (d < 3) ? 32'd1 : 32'd0);
        end
        step(2'b11, 2'b11, 7'd40, 7'd41, 1'b0, 1'b0, 1'b1, 2'b00, "halted_pop");
        checkOutput("unhalt", {31'd0, halted}, 32'd0);
        step(2'b11, 2'b11, 7'd40, 7'd41, 1'b0, 1'b0, 1'b1, 2'b11, "resume_pop");
        checkOutput("resume_flv", {31'd0, fl_valid}, 32'd1);
        checkOutput("resume_d0", {25'd0, fl_data[0]}, 32'd41);
        checkOutput("resume_ret", retire_cnt, 32'd8);

        // Recovery blocks commit but the release path keeps draining
        doReset();
        step(2'b11, 2'b11, 7'd31, 7'd30, 1'b0, 1'b0, 1'b0, 2'b11, "rq_pop");
        step(2'b11, 2'b11, 7'd33, 7'd32, 1'b0, 1'b0, 1'b0, 2'b11, "rq_pop");
        step(2'b11, 2'b11, 7'd35, 7'd34, 1'b1, 1'b0, 1'b1, 2'b00, "rec_pop");
        checkOutput("rec_flv", {31'd0, fl_valid}, 32'd1);
        checkOutput("rec_d0", {25'd0, fl_data[0]}, 32'd32);
        step(2'b11, 2'b11, 7'd37, 7'd36, 1'b0, 1'b0, 1'b1, 2'b11, "rec_resume");
        checkOutput("rec_resume_d0", {25'd0, fl_data[0]}, 32'd36);
        checkOutput("rec_ret", retire_cnt, 32'd6);

        // Asynchronous reset with two queued entries and seven retired
        doReset();
        for (int k = 0; k < 3; k++) begin
            step(2'b11, 2'b11, 7'd1, 7'd0, 1'b0, 1'b0, 1'b0, 2'b11, "mq_pop");
        end
        step(2'b00, 2'b00, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1, 2'b00, "mq_idle");
        step(2'b01, 2'b01, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1, 2'b01, "mq_one");
        checkOutput("mid_ret7", retire_cnt, 32'd7);
        checkOutput("mid_flv", {31'd0, fl_valid}, 32'd1);
        @(negedge clk);
        applyStimulus(2'b11, 2'b11, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_pop", {30'd0, rob_pop}, 32'd0);
        checkOutput("mid_rst_flv", {31'd0, fl_valid}, 32'd0);
        checkOutput("mid_rst_ret", retire_cnt, 32'd0);
        checkOutput("mid_rst_mask", {30'd0, fl_mask}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(2'b00, 2'b00, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("post_rst_flv", {31'd0, fl_valid}, 32'd0);
        step(2'b11, 2'b11, 7'd50, 7'd51, 1'b0, 1'b0, 1'b1, 2'b11, "post_rst_pop");
        checkOutput("post_rst_d0", {25'd0, fl_data[0]}, 32'd51);
        checkOutput("post_rst_ret", retire_cnt, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
